// File: rtl/picorv32_mem_sram_resp_if.sv
// picorv32_mem_sram_resp_if
//
// Bundles the picorv32 native memory bus (mem_*) and the single-port
// OpenRAM macro port (sram_*) seen by the SRAM responder.
//
// Handshake: the core raises mem_valid with a stable request and holds it
// until it sees mem_ready=1 for exactly one cycle; the responder latches the
// request on the edge that accepts it, so mem_* may change afterwards without
// effect. mem_rdata is meaningful only while mem_ready=1.
//
// Modports:
//   master : core/SRAM side (drives mem_valid/instr/addr/wdata/wstrb and sram_dout)
//   slave  : the responder (drives mem_ready/rdata and the sram_* controls)
`timescale 1ns/1ps
interface picorv32_mem_sram_resp_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  mem_valid;
    logic                  mem_instr;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_ready;
    logic [31:0]           mem_rdata;
    logic                  sram_csb;
    logic                  sram_web;
    logic [3:0]            sram_wmask;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [31:0]           sram_din;
    logic [31:0]           sram_dout;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, sram_dout,
        input  mem_ready, mem_rdata, sram_csb, sram_web, sram_wmask, sram_addr, sram_din
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, sram_dout,
        output mem_ready, mem_rdata, sram_csb, sram_web, sram_wmask, sram_addr, sram_din
    );
endinterface

// File: rtl/picorv32_mem_sram_resp.sv
// picorv32_mem_sram_resp
//
// Responder for the picorv32 native memory interface in front of a
// single-port sky130 OpenRAM macro. One request at a time; mem_ready is a
// one-cycle pulse followed by a guaranteed idle cycle. Requests outside the
// SRAM window complete in one cycle without an SRAM access.
//
// Ports:
//   clk, resetn     : clock, synchronous active-low reset
//   bus (slave)     : mem_* request/response and sram_* macro port
//   dbg_state       : current FSM state (0 IDLE, 1 ACCESS, 2 WAIT, 3 RESP)
//   mem_err,        : only with MEM_RESP_ERR_EN defined; sticky error flag
//   mem_err_addr      and address of the first out-of-range access
//
// Optional feature macro: MEM_RESP_ERR_EN.
`timescale 1ns/1ps
module picorv32_mem_sram_resp #(
    parameter int          ADDR_WIDTH   = 9,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] OOR_RDATA    = 32'h0000_0000
) (
    input  logic                            clk,
    input  logic                            resetn,
    picorv32_mem_sram_resp_if.slave         bus,
    output logic [1:0]                      dbg_state
`ifdef MEM_RESP_ERR_EN
    ,
    output logic                            mem_err,
    output logic [31:0]                     mem_err_addr
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Counter preload: WAIT lasts READ_LATENCY cycles, the last one captures dout.
    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [3:0]            wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           din_q, din_d;
`ifdef MEM_RESP_ERR_EN
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    logic                  err_q, err_d;
    logic [31:0]           err_addr_q, err_addr_d;
`endif

    logic in_range;
    logic unused_bits;

    assign in_range    = (bus.mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_instr};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        rdata_d = rdata_q;
        csb_d   = csb_q;
        web_d   = web_q;
        wmask_d = wmask_q;
        addr_d  = addr_q;
        din_d   = din_q;
`ifdef MEM_RESP_ERR_EN
        err_d      = err_q;
        err_addr_d = err_addr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.mem_valid) begin
                    if (in_range) begin
                        // The SRAM control registers double as the latched request.
                        state_d = ACCESS;
                        csb_d   = 1'b0;
                        addr_d  = bus.mem_addr[ADDR_WIDTH+1:2];
                        if (bus.mem_wstrb != 4'b0000) begin
                            web_d   = 1'b0;
                            wmask_d = bus.mem_wstrb;
                            din_d   = bus.mem_wdata;
                        end else begin
                            web_d   = 1'b1;
                            wmask_d = 4'b0000;
                        end
                    end else begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        if (bus.mem_wstrb == 4'b0000) begin
                            rdata_d = OOR_RDATA;
`ifdef MEM_RESP_ERR_EN
                            // A stray fetch traps into the debugger instead of running garbage.
                            if (bus.mem_instr) begin
                                rdata_d = EBREAK;
                            end
`endif
                        end
`ifdef MEM_RESP_ERR_EN
                        if (!err_q) begin
                            err_d      = 1'b1;
                            err_addr_d = bus.mem_addr;
                        end
`endif
                    end
                end
            end
            ACCESS: begin
                csb_d = 1'b1;
                web_d = 1'b1;
                if (!web_q) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    rdata_d = bus.sram_dout;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                // mem_valid is deliberately not looked at here.
                state_d = IDLE;
                ready_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= 4'b0000;
            addr_q  <= '0;
            din_q   <= 32'h0;
`ifdef MEM_RESP_ERR_EN
            err_q      <= 1'b0;
            err_addr_q <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
`ifdef MEM_RESP_ERR_EN
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
`endif
        end
    end

    assign bus.mem_ready  = ready_q;
    assign bus.mem_rdata  = rdata_q;
    assign bus.sram_csb   = csb_q;
    assign bus.sram_web   = web_q;
    assign bus.sram_wmask = wmask_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_din   = din_q;
    assign dbg_state      = state_q;
`ifdef MEM_RESP_ERR_EN
    assign mem_err        = err_q;
    assign mem_err_addr   = err_addr_q;
`endif

endmodule

// File: tb/tb_picorv32_mem_sram_resp.sv
// Bench for picorv32_mem_sram_resp. Two instances run in lockstep on the same
// request stream: dut_a with READ_LATENCY=1, dut_b with READ_LATENCY=3, each
// with its own behavioural SRAM. Expected responses go into per-instance
// queues at issue time; monitors pop and compare when mem_ready pulses.
`timescale 1ns/1ps
module tb_picorv32_mem_sram_resp;
    localparam int          AW     = 9;
    localparam logic [31:0] OOR    = 32'hBADC_0FFE;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic resetn;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    logic        valid_a, valid_b, t_instr;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_wstrb;
    logic [1:0]  dbg_a, dbg_b;

    picorv32_mem_sram_resp_if #(.ADDR_WIDTH(AW)) ifa ();
    picorv32_mem_sram_resp_if #(.ADDR_WIDTH(AW)) ifb ();

    assign ifa.mem_valid = valid_a;
    assign ifb.mem_valid = valid_b;
    assign ifa.mem_instr = t_instr;
    assign ifb.mem_instr = t_instr;
    assign ifa.mem_addr  = t_addr;
    assign ifb.mem_addr  = t_addr;
    assign ifa.mem_wdata = t_wdata;
    assign ifb.mem_wdata = t_wdata;
    assign ifa.mem_wstrb = t_wstrb;
    assign ifb.mem_wstrb = t_wstrb;

`ifdef MEM_RESP_ERR_EN
    logic        err_a, err_b;
    logic [31:0] err_addr_a, err_addr_b;
`endif

    picorv32_mem_sram_resp #(.ADDR_WIDTH(AW), .READ_LATENCY(1), .OOR_RDATA(OOR)) dut_a (
        .clk(clk), .resetn(resetn), .bus(ifa), .dbg_state(dbg_a)
`ifdef MEM_RESP_ERR_EN
        , .mem_err(err_a), .mem_err_addr(err_addr_a)
`endif
    );
    picorv32_mem_sram_resp #(.ADDR_WIDTH(AW), .READ_LATENCY(3), .OOR_RDATA(OOR)) dut_b (
        .clk(clk), .resetn(resetn), .bus(ifb), .dbg_state(dbg_b)
`ifdef MEM_RESP_ERR_EN
        , .mem_err(err_b), .mem_err_addr(err_addr_b)
`endif
    );

    // ---------------- SRAM models ----------------
    logic [31:0] mem_a [0:511];
    logic [31:0] mem_b [0:511];
    logic [31:0] pa [0:3];
    logic [31:0] pb [0:3];
    initial begin
        for (int i = 0; i < 512; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        for (int i = 0; i < 4; i++) begin
            pa[i] = 32'h0;
            pb[i] = 32'h0;
        end
    end
    assign ifa.sram_dout = pa[0];
    assign ifb.sram_dout = pb[2];

    always @(posedge clk) begin
        if (ifa.sram_csb === 1'b0) begin
            if (ifa.sram_web === 1'b0) begin
                for (int b = 0; b < 4; b++)
                    if (ifa.sram_wmask[b]) mem_a[ifa.sram_addr][8*b +: 8] <= ifa.sram_din[8*b +: 8];
            end else begin
                pa[0] <= mem_a[ifa.sram_addr];
            end
        end
        for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
    end
    always @(posedge clk) begin
        if (ifb.sram_csb === 1'b0) begin
            if (ifb.sram_web === 1'b0) begin
                for (int b = 0; b < 4; b++)
                    if (ifb.sram_wmask[b]) mem_b[ifb.sram_addr][8*b +: 8] <= ifb.sram_din[8*b +: 8];
            end else begin
                pb[0] <= mem_b[ifb.sram_addr];
            end
        end
        for (int i = 1; i < 4; i++) pb[i] <= pb[i-1];
    end

    // ---------------- SRAM port snoop ----------------
    int          csb_cnt_a = 0, csb_cnt_b = 0;
    logic [8:0]  s_addr_a, s_addr_b;
    logic        s_web_a, s_web_b;
    logic [3:0]  s_wmask_a, s_wmask_b;
    logic [31:0] s_din_a, s_din_b;
    always @(negedge clk) begin
        if (ifa.sram_csb === 1'b0) begin
            csb_cnt_a <= csb_cnt_a + 1;
            s_addr_a  <= ifa.sram_addr;
            s_web_a   <= ifa.sram_web;
            s_wmask_a <= ifa.sram_wmask;
            s_din_a   <= ifa.sram_din;
        end
        if (ifb.sram_csb === 1'b0) begin
            csb_cnt_b <= csb_cnt_b + 1;
            s_addr_b  <= ifb.sram_addr;
            s_web_b   <= ifb.sram_web;
            s_wmask_b <= ifb.sram_wmask;
            s_din_b   <= ifb.sram_din;
        end
    end

    // ---------------- scoreboard ----------------
    // entry = {accept_edge[15:0], latency[7:0], rdata[31:0]}
    logic [55:0] qa[$];
    logic [55:0] qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon(input string tag, input logic [31:0] rdata, inout logic [55:0] q[$]);
        logic [55:0] e;
        if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_unexpected_ready: got mem_ready=1 expected no response (t=%0t)", tag, $time);
        end else begin
            e = q.pop_front();
            chk({tag, "_rdata"}, rdata, e[31:0]);
            chk({tag, "_latency"}, 32'(cyc - int'(e[55:40]) + 1), {24'h0, e[39:32]});
        end
    endtask

    always @(negedge clk) if (ifa.mem_ready === 1'b1) mon("a", ifa.mem_rdata, qa);
    always @(negedge clk) if (ifb.mem_ready === 1'b1) mon("b", ifb.mem_rdata, qb);

    // ---------------- driver ----------------
    task automatic wait_ready_a();
        bit done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifa.mem_ready === 1'b1) begin
                valid_a = 1'b0;
                done = 1;
                break;
            end
        end
        if (!done) begin
            valid_a = 1'b0;
            chk("a_ready_timeout", 32'h0, 32'h1);
        end
    endtask

    task automatic wait_ready_b();
        bit done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifb.mem_ready === 1'b1) begin
                valid_b = 1'b0;
                done = 1;
                break;
            end
        end
        if (!done) begin
            valid_b = 1'b0;
            chk("b_ready_timeout", 32'h0, 32'h1);
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic instr, input logic [31:0] exp_rdata, input bit in_range);
        int sa, sb, la, lb;
        bit wr;
        wr = (wstrb != 4'b0000);
        la = !in_range ? 1 : (wr ? 2 : 3);
        lb = !in_range ? 1 : (wr ? 2 : 5);
        @(negedge clk);
        sa = csb_cnt_a;
        sb = csb_cnt_b;
        t_addr  = addr;
        t_wdata = wdata;
        t_wstrb = wstrb;
        t_instr = instr;
        valid_a = 1'b1;
        valid_b = 1'b1;
        qa.push_back({16'(cyc + 1), 8'(la), exp_rdata});
        qb.push_back({16'(cyc + 1), 8'(lb), exp_rdata});
        fork
            wait_ready_a();
            wait_ready_b();
            if (in_range) begin
                // Scribble on the bus after acceptance; the latched request must win.
                @(negedge clk);
                #1;
                t_addr  = $urandom;
                t_wdata = $urandom;
                t_wstrb = 4'($urandom_range(0, 15));
                t_instr = 1'b1;
            end
        join
        chk("a_csb_cycles", 32'(csb_cnt_a - sa), in_range ? 32'd1 : 32'd0);
        chk("b_csb_cycles", 32'(csb_cnt_b - sb), in_range ? 32'd1 : 32'd0);
        if (in_range) begin
            chk("a_sram_addr", {23'h0, s_addr_a}, {23'h0, addr[10:2]});
            chk("b_sram_addr", {23'h0, s_addr_b}, {23'h0, addr[10:2]});
            chk("a_sram_web", {31'h0, s_web_a}, {31'h0, !wr});
            chk("b_sram_web", {31'h0, s_web_b}, {31'h0, !wr});
            if (wr) begin
                chk("a_sram_wmask", {28'h0, s_wmask_a}, {28'h0, wstrb});
                chk("a_sram_din", s_din_a, wdata);
                chk("b_sram_wmask", {28'h0, s_wmask_b}, {28'h0, wstrb});
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        resetn  = 1'b0;
        valid_a = 1'b1;
        valid_b = 1'b1;
        t_instr = 1'b0;
        t_addr  = 32'h10;
        t_wdata = 32'h0;
        t_wstrb = 4'hF;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready_a", {31'h0, ifa.mem_ready}, 32'h0);
            chk("rst_csb_a", {31'h0, ifa.sram_csb}, 32'h1);
            chk("rst_web_a", {31'h0, ifa.sram_web}, 32'h1);
            chk("rst_ready_b", {31'h0, ifb.mem_ready}, 32'h0);
            chk("rst_csb_b", {31'h0, ifb.sram_csb}, 32'h1);
            chk("rst_web_b", {31'h0, ifb.sram_web}, 32'h1);
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        resetn  = 1'b1;
        chk("rst_rdata_a", ifa.mem_rdata, 32'h0);
        chk("rst_wmask_a", {28'h0, ifa.sram_wmask}, 32'h0);
        chk("rst_addr_a", {23'h0, ifa.sram_addr}, 32'h0);
        chk("rst_din_a", ifa.sram_din, 32'h0);
        chk("rst_state_a", {30'h0, dbg_a}, 32'h0);
        chk("rst_state_b", {30'h0, dbg_b}, 32'h0);
`ifdef MEM_RESP_ERR_EN
        chk("rst_err_a", {31'h0, err_a}, 32'h0);
        chk("rst_err_addr_a", err_addr_a, 32'h0);
`endif

        do_req(32'h0000_0010, 32'hDEAD_BEEF, 4'hF,    1'b0, 32'h0000_0000, 1);
        do_req(32'h0000_0010, 32'h0,         4'h0,    1'b0, 32'hDEAD_BEEF, 1);
        do_req(32'h0000_0010, 32'h00AA_0000, 4'b0100, 1'b0, 32'hDEAD_BEEF, 1);
        do_req(32'h0000_0010, 32'h0,         4'h0,    1'b0, 32'hDEAA_BEEF, 1);
        do_req(32'h0000_07FC, 32'h1234_5678, 4'b0011, 1'b0, 32'hDEAA_BEEF, 1);
        do_req(32'h0000_07FC, 32'h0,         4'h0,    1'b0, 32'h0000_5678, 1);
        do_req(32'h0000_0020, 32'h0000_00A5, 4'b0001, 1'b0, 32'h0000_5678, 1);
        do_req(32'h0000_0020, 32'h1234_0000, 4'b1100, 1'b0, 32'h0000_5678, 1);
        do_req(32'h0000_0020, 32'h0,         4'h0,    1'b0, 32'h1234_00A5, 1);
        do_req(32'h0000_0800, 32'h0,         4'h0,    1'b0, OOR,           0);
`ifdef MEM_RESP_ERR_EN
        chk("oor_err_a", {31'h0, err_a}, 32'h1);
        chk("oor_err_addr_a", err_addr_a, 32'h0000_0800);
        chk("oor_err_b", {31'h0, err_b}, 32'h1);
`endif
        do_req(32'h0000_0900, 32'hFFFF_FFFF, 4'hF,    1'b0, OOR,           0);
`ifdef MEM_RESP_ERR_EN
        chk("oor2_err_addr_a", err_addr_a, 32'h0000_0800);
        chk("oor2_err_addr_b", err_addr_b, 32'h0000_0800);
        do_req(32'h0000_0A00, 32'h0,         4'h0,    1'b1, EBREAK,        0);
`endif

        // Reset while both instances sit in WAIT: no response may appear.
        @(negedge clk);
        t_addr  = 32'h10;
        t_wstrb = 4'h0;
        t_instr = 1'b0;
        valid_a = 1'b1;
        valid_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("wait_state_a", {30'h0, dbg_a}, 32'h2);
        chk("wait_state_b", {30'h0, dbg_b}, 32'h2);
        resetn  = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("abort_state_a", {30'h0, dbg_a}, 32'h0);
        chk("abort_state_b", {30'h0, dbg_b}, 32'h0);
        chk("abort_ready_a", {31'h0, ifa.mem_ready}, 32'h0);
        chk("abort_ready_b", {31'h0, ifb.mem_ready}, 32'h0);
        chk("abort_rdata_b", ifb.mem_rdata, 32'h0);
`ifdef MEM_RESP_ERR_EN
        chk("abort_err_a", {31'h0, err_a}, 32'h0);
`endif
        repeat (4) @(negedge clk);
        do_req(32'h0000_0010, 32'h0,         4'h0,    1'b0, 32'hDEAA_BEEF, 1);

        repeat (3) @(negedge clk);
        chk("a_queue_empty", 32'(qa.size()), 32'h0);
        chk("b_queue_empty", 32'(qb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
